vz_saver: RTL and testbench
===========================

Name: vz_saver

Overview:
- Opposite direction of the VZ snapshot load path: reads a program out of Laser310 RAM and streams it as a .vz file byte sequence for host upload.
- Sits between the CPU RAM read port (arbitrated while the CPU is held) and the ioctl upload side.
- BASIC mode: program bounds come from the system variables. Machine-code mode: bounds come from ports.
- Output is a 24-byte header followed by the body bytes.

Parameters:
- RD_LAT, 1, memory read latency in cycles from mem_rd to mem_data valid (1..4).
- MAX_BODY, 16'hFFE7, largest body length accepted; keeps the total file within a 16-bit address.

Ports:
- I_CLK  in  1  clock
- I_RST  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a save; ignored while busy
- mode_mcode  in  1  0 = BASIC (type 0xF0), 1 = machine code (type 0xF1); sampled on start
- mc_start  in  16  mcode first address; sampled on start
- mc_end  in  16  mcode end address, exclusive; sampled on start
- prog_name  in  128  name; byte i = prog_name[8i+7:8i]; sampled on start
- mem_addr  out  16  RAM read address
- mem_rd  out  1  one-cycle read strobe
- mem_data  in  8  read data, valid RD_LAT cycles after mem_rd
- out_addr  out  16  file offset of out_data
- out_data  out  8  file byte
- out_valid  out  1  byte available
- out_ready  in  1  consumer accepts when out_valid && out_ready
- busy  out  1  save in progress
- done  out  1  one-cycle pulse after the last byte is accepted
- error  out  1  sticky bad-bounds flag; cleared by the next accepted start
- led  out  1  equals busy

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Reset mid-save aborts immediately; no done pulse is issued.
- Start in IDLE: latch the sampled inputs, set busy and clear error on the next edge.
  - BASIC: go to PTR.
  - mcode: start_a = mc_start, end_a = mc_end; go to CHK.
- PTR: read 0x78A4, 0x78A5, 0x78F9, 0x78FA in that order, one outstanding read at a time.
  - start_a = {78A5, 78A4}.
  - end_a = {78FA, 78F9}.
- CHK: len = end_a - start_a (16-bit).
  - If end_a <= start_a or len > MAX_BODY: set error, drop busy, return to IDLE. Emit no bytes and no done.
- HDR: emit 24 bytes at out_addr 0..23:
  - bytes 0..3: 'V','Z','F','0' (0x56, 0x5A, 0x46, 0x30)
  - bytes 4..19: name bytes 0..15
  - byte 20: 0x00
  - byte 21: type (0xF0 or 0xF1)
  - byte 22: start_a[7:0]
  - byte 23: start_a[15:8]
- BODY: for k = 0..len-1:
  - Assert mem_rd with mem_addr = start_a + k.
  - Capture mem_data after RD_LAT cycles and present it at out_addr 24 + k.
  - Issue the next read only after the current byte is accepted (single-byte buffer, no prefetch).
- Handshake:
  - out_valid rises with stable out_addr/out_data and holds until accepted.
  - out_ready may be held high; throughput is then 1 byte/cycle in HDR and 1 byte per RD_LAT+1 cycles in BODY.
  - out_valid is 0 in IDLE, PTR and CHK.
- Completion: the cycle after the final byte is accepted, done = 1 for one cycle and busy = 0; the FSM returns to IDLE.
- Address arithmetic: start_a + k wraps at 16 bits; with len <= MAX_BODY, out_addr never wraps.
- A start pulse during busy has no effect.

Optional Feature:
- Macro: VZ_SAVER_CKSUM_EN.
- Defined: after the body, emit 2 trailer bytes at out_addr 24+len and 25+len. They carry the 16-bit wrap-around sum of the body bytes, low byte first. MAX_BODY is effectively reduced by 2 (bounds check uses len > MAX_BODY-2). done follows the trailer.
- Undefined: no trailer; the file ends after the body.

Test Plan:
- BASIC save: RAM 78A4=E9, 78A5=7A, 78F9=F9, 78FA=7A; body 7AE9..7AF8 = 00..0F; start with out_ready=1 -> 40 bytes. Bytes 0..3 = 56 5A 46 30, byte 21 = F0, byte 22 = E9, byte 23 = 7A, bytes 24..39 = 00..0F; single done pulse; error = 0.
- Mcode save: mc_start=8000, mc_end=8003, RAM = AA BB CC, name "HELLO" -> byte 4 = 48, byte 21 = F1, byte 22 = 00, byte 23 = 80; out_addr 24..26 carry AA BB CC; 27 bytes total.
- Backpressure: random out_ready, including 10 low cycles mid-body -> out_addr/out_data hold while out_valid is high; byte sequence is identical to the run with out_ready=1.
- Bad bounds: mc_start=9000, mc_end=9000 -> error=1, no out_valid, no done. A later valid start clears error.
- Reset mid-body at byte 30 -> next cycle: busy, out_valid, mem_rd all 0. A fresh save then completes normally from out_addr 0.
- VZ_SAVER_CKSUM_EN, body FF FF 02 -> trailer bytes 00 02 at offsets 27, 28; done after offset 28.

Source files
------------

// File: rtl/vz_saver.sv
// vz_saver: reads a Laser310 program out of RAM and streams it as a .vz file (24-byte header + body).
// Build option VZ_SAVER_CKSUM_EN appends a 16-bit wrap-around body checksum, low byte first.
module vz_saver #(
  parameter int          RD_LAT   = 1,
  parameter logic [15:0] MAX_BODY = 16'hFFE7
) (
  input  logic         I_CLK,
  input  logic         I_RST,
  input  logic         start,
  input  logic         mode_mcode,
  input  logic [15:0]  mc_start,
  input  logic [15:0]  mc_end,
  input  logic [127:0] prog_name,
  output logic [15:0]  mem_addr,
  output logic         mem_rd,
  input  logic [7:0]   mem_data,
  output logic [15:0]  out_addr,
  output logic [7:0]   out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         led
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PTR  = 3'd1;
  localparam logic [2:0] S_CHK  = 3'd2;
  localparam logic [2:0] S_HDR  = 3'd3;
  localparam logic [2:0] S_BODY = 3'd4;
`ifdef VZ_SAVER_CKSUM_EN
  localparam logic [2:0]  S_TRL = 3'd5;
  localparam logic [15:0] LIMIT = MAX_BODY - 16'd2;
`else
  localparam logic [15:0] LIMIT = MAX_BODY;
`endif

  logic [2:0]   state_r;
  logic         mcode_r;
  logic [127:0] name_r;
  logic [15:0]  start_a_r;
  logic [15:0]  end_a_r;
  logic [15:0]  last_addr_r;
  logic [1:0]   ptr_idx_r;
  logic         rd_pend_r;
  logic [2:0]   lat_cnt_r;
  logic [15:0]  out_addr_r;
  logic [7:0]   out_data_r;
  logic         out_valid_r;
  logic         busy_r;
  logic         done_r;
  logic         error_r;
`ifdef VZ_SAVER_CKSUM_EN
  logic [15:0]  sum_r;
`endif

  logic         accept_s;
  logic         rd_done_s;
  logic [15:0]  len_s;
  logic         mem_rd_s;
  logic [15:0]  mem_addr_s;

  function automatic logic [7:0] hdr_byte(input logic [4:0] idx, input logic [127:0] name,
                                          input logic mc, input logic [15:0] sa);
    logic [3:0] ni;
    ni = idx[3:0] - 4'd4;
    case (idx)
      5'd0:    hdr_byte = 8'h56;
      5'd1:    hdr_byte = 8'h5A;
      5'd2:    hdr_byte = 8'h46;
      5'd3:    hdr_byte = 8'h30;
      5'd20:   hdr_byte = 8'h00;
      5'd21:   hdr_byte = mc ? 8'hF1 : 8'hF0;
      5'd22:   hdr_byte = sa[7:0];
      5'd23:   hdr_byte = sa[15:8];
      default: begin
        if (idx >= 5'd4 && idx <= 5'd19) hdr_byte = name[{ni, 3'b000} +: 8];
        else hdr_byte = 8'h00;
      end
    endcase
  endfunction

  function automatic logic [15:0] ptr_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    ptr_addr = 16'h78A4;
      2'd1:    ptr_addr = 16'h78A5;
      2'd2:    ptr_addr = 16'h78F9;
      2'd3:    ptr_addr = 16'h78FA;
      default: ptr_addr = 16'h0000;
    endcase
  endfunction

  assign accept_s  = out_valid_r & out_ready;
  assign rd_done_s = rd_pend_r && (lat_cnt_r == 3'd0);
  assign len_s     = end_a_r - start_a_r;

  // Read issue: the next body read goes out in the same cycle the previous byte is accepted.
  always_comb begin
    mem_rd_s   = 1'b0;
    mem_addr_s = 16'h0000;
    case (state_r)
      S_PTR: begin
        mem_addr_s = ptr_addr(ptr_idx_r);
        if (!rd_pend_r) mem_rd_s = 1'b1;
        else mem_rd_s = 1'b0;
      end
      S_HDR: begin
        mem_addr_s = start_a_r;
        if (accept_s && out_addr_r == 16'd23) mem_rd_s = 1'b1;
        else mem_rd_s = 1'b0;
      end
      S_BODY: begin
        mem_addr_s = start_a_r + out_addr_r - 16'd23;
        if (accept_s && out_addr_r != last_addr_r) mem_rd_s = 1'b1;
        else mem_rd_s = 1'b0;
      end
      default: begin
        mem_rd_s   = 1'b0;
        mem_addr_s = 16'h0000;
      end
    endcase
  end

  // Main sequencer: read latency tracking, bounds check and byte streaming.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_r     <= S_IDLE;
      mcode_r     <= 1'b0;
      name_r      <= 128'h0;
      start_a_r   <= 16'h0000;
      end_a_r     <= 16'h0000;
      last_addr_r <= 16'h0000;
      ptr_idx_r   <= 2'd0;
      rd_pend_r   <= 1'b0;
      lat_cnt_r   <= 3'd0;
      out_addr_r  <= 16'h0000;
      out_data_r  <= 8'h00;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
`ifdef VZ_SAVER_CKSUM_EN
      sum_r       <= 16'h0000;
`endif
    end else begin
      done_r <= 1'b0;
      if (mem_rd_s) begin
        rd_pend_r <= 1'b1;
        lat_cnt_r <= 3'(RD_LAT - 1);
      end else if (rd_pend_r) begin
        if (lat_cnt_r == 3'd0) rd_pend_r <= 1'b0;
        else lat_cnt_r <= lat_cnt_r - 3'd1;
      end
      case (state_r)
        S_IDLE: begin
          if (start) begin
            mcode_r   <= mode_mcode;
            name_r    <= prog_name;
            busy_r    <= 1'b1;
            error_r   <= 1'b0;
            ptr_idx_r <= 2'd0;
`ifdef VZ_SAVER_CKSUM_EN
            sum_r     <= 16'h0000;
`endif
            if (mode_mcode) begin
              start_a_r <= mc_start;
              end_a_r   <= mc_end;
              state_r   <= S_CHK;
            end else begin
              state_r   <= S_PTR;
            end
          end
        end
        S_PTR: begin
          if (rd_done_s) begin
            case (ptr_idx_r)
              2'd0:    start_a_r[7:0]  <= mem_data;
              2'd1:    start_a_r[15:8] <= mem_data;
              2'd2:    end_a_r[7:0]    <= mem_data;
              default: end_a_r[15:8]   <= mem_data;
            endcase
            ptr_idx_r <= ptr_idx_r + 2'd1;
            if (ptr_idx_r == 2'd3) state_r <= S_CHK;
          end
        end
        S_CHK: begin
          if (end_a_r <= start_a_r || len_s > LIMIT) begin
            error_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end else begin
            last_addr_r <= len_s + 16'd23;
            out_addr_r  <= 16'h0000;
            out_data_r  <= 8'h56;
            out_valid_r <= 1'b1;
            state_r     <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept_s) begin
            out_addr_r <= out_addr_r + 16'd1;
            if (out_addr_r == 16'd23) begin
              out_valid_r <= 1'b0;
              state_r     <= S_BODY;
            end else begin
              out_data_r <= hdr_byte(out_addr_r[4:0] + 5'd1, name_r, mcode_r, start_a_r);
            end
          end
        end
        S_BODY: begin
          if (rd_done_s) begin
            out_data_r  <= mem_data;
            out_valid_r <= 1'b1;
`ifdef VZ_SAVER_CKSUM_EN
            sum_r       <= sum_r + {8'h00, mem_data};
`endif
          end else if (accept_s) begin
            if (out_addr_r == last_addr_r) begin
`ifdef VZ_SAVER_CKSUM_EN
              out_addr_r <= out_addr_r + 16'd1;
              out_data_r <= sum_r[7:0];
              state_r    <= S_TRL;
`else
              out_valid_r <= 1'b0;
              out_addr_r  <= 16'h0000;
              out_data_r  <= 8'h00;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= S_IDLE;
`endif
            end else begin
              out_valid_r <= 1'b0;
              out_addr_r  <= out_addr_r + 16'd1;
            end
          end
        end
`ifdef VZ_SAVER_CKSUM_EN
        S_TRL: begin
          if (accept_s) begin
            if (out_addr_r == last_addr_r + 16'd1) begin
              out_addr_r <= out_addr_r + 16'd1;
              out_data_r <= sum_r[15:8];
            end else begin
              out_valid_r <= 1'b0;
              out_addr_r  <= 16'h0000;
              out_data_r  <= 8'h00;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
              state_r     <= S_IDLE;
            end
          end
        end
`endif
        default: begin
          state_r     <= S_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd    = mem_rd_s;
  assign mem_addr  = mem_addr_s;
  assign out_addr  = out_addr_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign error     = error_r;
  assign led       = busy_r;

endmodule

// File: tb/tb_vz_saver.sv
// Directed self-checking bench for vz_saver with a 1-cycle-latency RAM model.
module tb_vz_saver;

`ifdef VZ_SAVER_CKSUM_EN
  localparam int TRL = 2;
`else
  localparam int TRL = 0;
`endif

  logic         I_CLK = 1'b0;
  logic         I_RST = 1'b1;
  logic         start = 1'b0;
  logic         mode_mcode = 1'b0;
  logic [15:0]  mc_start = 16'h0;
  logic [15:0]  mc_end = 16'h0;
  logic [127:0] prog_name = 128'h0;
  logic [15:0]  mem_addr;
  logic         mem_rd;
  logic [7:0]   mem_data = 8'h00;
  logic [15:0]  out_addr;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;
  logic         error;
  logic         led;

  logic [7:0]   ram [0:65535];
  logic [15:0]  cap_addr [0:1023];
  logic [7:0]   cap_data [0:1023];
  logic [7:0]   exp_b [0:41];
  int           cap_n = 0;
  int           done_cnt = 0;
  int           valid_cnt = 0;
  int           hold_err = 0;
  logic         prev_v = 1'b0;
  logic         prev_r = 1'b0;
  logic [15:0]  prev_a = 16'h0;
  logic [7:0]   prev_d = 8'h0;
  int           n_assert = 0;
  int           n_fail = 0;
  int           base;
  int           dbase;
  int           vbase;
  logic         seen;
  logic         win_done;
  logic [127:0] name_b;
  logic [127:0] name_h;

  vz_saver dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .start(start), .mode_mcode(mode_mcode),
    .mc_start(mc_start), .mc_end(mc_end), .prog_name(prog_name),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_addr(out_addr), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error), .led(led)
  );

  always #5 I_CLK = ~I_CLK;

  // RAM model: data appears the cycle after the read strobe.
  always @(posedge I_CLK) begin
    if (mem_rd) mem_data <= ram[mem_addr];
  end

  // Monitor: records accepted bytes, done pulses and hold violations under backpressure.
  always @(negedge I_CLK) begin
    if (prev_v && !prev_r && !I_RST &&
        !(out_valid && out_addr == prev_a && out_data == prev_d)) hold_err <= hold_err + 1;
    if (out_valid && out_ready && cap_n < 1024) begin
      cap_addr[cap_n] <= out_addr;
      cap_data[cap_n] <= out_data;
      cap_n <= cap_n + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid) valid_cnt <= valid_cnt + 1;
    prev_v <= out_valid;
    prev_r <= out_ready;
    prev_a <= out_addr;
    prev_d <= out_data;
  end

  task automatic step;
    @(posedge I_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic m, input logic [15:0] s, input logic [15:0] e,
                          input logic [127:0] nm);
    mode_mcode = m;
    mc_start   = s;
    mc_end     = e;
    prog_name  = nm;
    start      = 1'b1;
    step;
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    logic got;
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      step;
      if (done_cnt > dbase) got = 1'b1;
    end
    chk(tag, {31'h0, got}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h78A4] = 8'hE9; ram[16'h78A5] = 8'h7A;
    ram[16'h78F9] = 8'hF9; ram[16'h78FA] = 8'h7A;
    for (int i = 0; i < 16; i++) ram[16'h7AE9 + i] = 8'(i);
    ram[16'h8000] = 8'hAA; ram[16'h8001] = 8'hBB; ram[16'h8002] = 8'hCC;
    ram[16'hA000] = 8'hFF; ram[16'hA001] = 8'hFF; ram[16'hA002] = 8'h02;
    name_b = 128'h0;
    name_b[7:0] = 8'h42;
    name_b[127:120] = 8'h5A;
    name_h = 128'h0;
    name_h[39:0] = 40'h4F_4C_4C_45_48;
    exp_b[0] = 8'h56; exp_b[1] = 8'h5A; exp_b[2] = 8'h46; exp_b[3] = 8'h30;
    for (int i = 4; i < 20; i++) exp_b[i] = 8'h00;
    exp_b[4] = 8'h42; exp_b[19] = 8'h5A;
    exp_b[20] = 8'h00; exp_b[21] = 8'hF0; exp_b[22] = 8'hE9; exp_b[23] = 8'h7A;
    for (int i = 0; i < 16; i++) exp_b[24 + i] = 8'(i);
    exp_b[40] = 8'h78; exp_b[41] = 8'h00;

    // Reset state
    repeat (3) step;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_memrd", {31'h0, mem_rd}, 32'h0);
    chk("rst_led", {31'h0, led}, 32'h0);
    chk("rst_oaddr", {16'h0, out_addr}, 32'h0);
    I_RST = 1'b0;
    step;

    // BASIC save, out_ready held high
    out_ready = 1'b1;
    base = cap_n; dbase = done_cnt;
    do_start(1'b0, 16'h0, 16'h0, name_b);
    chk("basic_busy", {31'h0, busy}, 32'h1);
    chk("basic_led", {31'h0, led}, 32'h1);
    wait_done("basic_timeout", 400);
    step;
    chk("basic_count", cap_n - base, 40 + TRL);
    for (int i = 0; i < 40 + TRL; i++) begin
      chk($sformatf("basic_addr%0d", i), {16'h0, cap_addr[base + i]}, i);
      chk($sformatf("basic_byte%0d", i), {24'h0, cap_data[base + i]}, {24'h0, exp_b[i]});
    end
    chk("basic_done_once", done_cnt - dbase, 1);
    chk("basic_error", {31'h0, error}, 32'h0);
    chk("basic_idle_busy", {31'h0, busy}, 32'h0);

    // Machine-code save
    base = cap_n; dbase = done_cnt;
    do_start(1'b1, 16'h8000, 16'h8003, name_h);
    wait_done("mc_timeout", 200);
    step;
    chk("mc_count", cap_n - base, 27 + TRL);
    chk("mc_b4", {24'h0, cap_data[base + 4]}, 32'h48);
    chk("mc_b8", {24'h0, cap_data[base + 8]}, 32'h4F);
    chk("mc_b21", {24'h0, cap_data[base + 21]}, 32'hF1);
    chk("mc_b22", {24'h0, cap_data[base + 22]}, 32'h00);
    chk("mc_b23", {24'h0, cap_data[base + 23]}, 32'h80);
    chk("mc_b24", {24'h0, cap_data[base + 24]}, 32'hAA);
    chk("mc_b25", {24'h0, cap_data[base + 25]}, 32'hBB);
    chk("mc_b26", {24'h0, cap_data[base + 26]}, 32'hCC);
    chk("mc_a26", {16'h0, cap_addr[base + 26]}, 32'd26);

    // Backpressure: random ready plus a 10-cycle stall mid-body
    base = cap_n; dbase = done_cnt; win_done = 1'b0; seen = 1'b0;
    do_start(1'b0, 16'h0, 16'h0, name_b);
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (!win_done && cap_n - base >= 30) begin
        out_ready = 1'b0;
        repeat (10) step;
        win_done = 1'b1;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        step;
      end
      if (done_cnt > dbase) seen = 1'b1;
    end
    chk("bp_timeout", {31'h0, seen}, 32'h1);
    out_ready = 1'b1;
    step;
    chk("bp_count", cap_n - base, 40 + TRL);
    for (int i = 0; i < 40 + TRL; i++) begin
      chk($sformatf("bp_addr%0d", i), {16'h0, cap_addr[base + i]}, i);
      chk($sformatf("bp_byte%0d", i), {24'h0, cap_data[base + i]}, {24'h0, exp_b[i]});
    end
    chk("bp_hold", hold_err, 0);
    chk("bp_done_once", done_cnt - dbase, 1);

    // Bad bounds: empty range
    base = cap_n; dbase = done_cnt; vbase = valid_cnt;
    do_start(1'b1, 16'h9000, 16'h9000, name_h);
    repeat (10) step;
    chk("bad_error", {31'h0, error}, 32'h1);
    chk("bad_busy", {31'h0, busy}, 32'h0);
    chk("bad_novalid", valid_cnt - vbase, 0);
    chk("bad_nodone", done_cnt - dbase, 0);

    // Bad bounds: one over the body limit
    do_start(1'b1, 16'h0000, 16'hFFE8, name_h);
    repeat (5) step;
    chk("big_error", {31'h0, error}, 32'h1);
    chk("big_novalid", valid_cnt - vbase, 0);

    // Largest length accepted in every build: header begins, then abort with reset
    out_ready = 1'b0;
    do_start(1'b1, 16'h0000, 16'hFFE5, name_h);
    chk("lim_err_clr", {31'h0, error}, 32'h0);
    repeat (3) step;
    chk("lim_busy", {31'h0, busy}, 32'h1);
    chk("lim_valid", {31'h0, out_valid}, 32'h1);
    chk("lim_data", {24'h0, out_data}, 32'h56);
    I_RST = 1'b1;
    step;
    I_RST = 1'b0;
    out_ready = 1'b1;

    // Error is set again, then cleared by a valid start
    do_start(1'b1, 16'h9000, 16'h8FFF, name_h);
    repeat (4) step;
    chk("wrap_error", {31'h0, error}, 32'h1);
    dbase = done_cnt;
    do_start(1'b1, 16'h8000, 16'h8003, name_h);
    chk("clr_error", {31'h0, error}, 32'h0);
    wait_done("clr_timeout", 200);

    // Reset mid-body at byte 30
    step;
    base = cap_n; dbase = done_cnt; seen = 1'b0;
    do_start(1'b0, 16'h0, 16'h0, name_b);
    for (int c = 0; c < 300 && !seen; c++) begin
      step;
      if (cap_n - base >= 30) seen = 1'b1;
    end
    chk("mid_reach30", {31'h0, seen}, 32'h1);
    I_RST = 1'b1;
    step;
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_memrd", {31'h0, mem_rd}, 32'h0);
    I_RST = 1'b0;
    step;
    chk("mid_nodone", done_cnt - dbase, 0);
    base = cap_n; dbase = done_cnt;
    do_start(1'b1, 16'h8000, 16'h8003, name_h);
    wait_done("fresh_timeout", 200);
    step;
    chk("fresh_first_addr", {16'h0, cap_addr[base]}, 32'h0);
    chk("fresh_count", cap_n - base, 27 + TRL);
    chk("fresh_b24", {24'h0, cap_data[base + 24]}, 32'hAA);

    // Checksum body FF FF 02
    base = cap_n; dbase = done_cnt;
    do_start(1'b1, 16'hA000, 16'hA003, name_h);
    wait_done("ck_timeout", 200);
    step;
    chk("ck_count", cap_n - base, 27 + TRL);
    chk("ck_b26", {24'h0, cap_data[base + 26]}, 32'h02);
`ifdef VZ_SAVER_CKSUM_EN
    chk("ck_a27", {16'h0, cap_addr[base + 27]}, 32'd27);
    chk("ck_b27", {24'h0, cap_data[base + 27]}, 32'h00);
    chk("ck_a28", {16'h0, cap_addr[base + 28]}, 32'd28);
    chk("ck_b28", {24'h0, cap_data[base + 28]}, 32'h02);
`endif
    chk("ck_done_once", done_cnt - dbase, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
